// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte-level bit engine: command codes,
// FSM states and quarter-period indices.
package i2c_pkg;

  // Command encodings on the 2-bit cmd input
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Top-level sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_STOP  = 2'd2,
    ST_BIT   = 2'd3
  } state_t;

  // Quarter indices within one SCL period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Index of the 9th (acknowledge) bit of a byte transfer
  localparam logic [3:0] LAST_BIT = 4'd8;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period prescaler for the I2C bit engine. Counts CLK_DIV cycles per
// quarter and steps a 2-bit quarter index. While SCL is released by us but
// held low by a slave, the count freezes so stretching lengthens the quarter.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       run,
  input  logic       scl_oen,
  input  logic       scl_i,
  output logic       q_last,
  output logic       q_first,
  output logic [1:0] quarter
);

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       stretch;

  // A slave is stretching when we release SCL but the pin still reads low
  assign stretch = scl_oen & ~scl_i;

  // q_first/q_last are only asserted on cycles where the count advances,
  // so each fires exactly once per quarter even under stretching
  assign q_last  = run & ~stretch & (cnt == CNT_MAX);
  assign q_first = run & ~stretch & (cnt == 8'd0);

  // Prescaler and quarter index; both park at zero while idle
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      quarter <= Q0;
    end else if (!run) begin
      cnt     <= 8'd0;
      quarter <= Q0;
    end else if (!stretch) begin
      if (cnt == CNT_MAX) begin
        cnt     <= 8'd0;
        quarter <= quarter + 2'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_bit_engine.sv
// Byte-level I2C master bus driver. Executes START/STOP/WRITE/READ commands
// one at a time, producing registered open-drain enables for SCL and SDA with
// quarter-period timing supplied by i2c_quarter_tick.
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_nack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_rcvd,
  output logic       done,
  output logic       busy,
  output logic       scl_oen,
  output logic       sda_oen,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_t     state;
  state_t     state_next;
  logic [3:0] bit_cnt;
  logic [7:0] shift_data;
  logic       is_read;
  logic       nack_bit;
  logic       ack_sample;
  logic       scl_next;
  logic       sda_next;
  logic       finish;
  logic       accept;
  logic       run;
  logic       last_bit;
  logic       bit_level;
  logic       q_last;
  logic       q_first;
  logic [1:0] quarter;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign run       = (state != ST_IDLE);
  assign last_bit  = (bit_cnt == LAST_BIT);

  // SDA level for the current data bit: data MSB for WRITE, released for READ
  // data bits; in the 9th bit the slave acks a WRITE, we ack/nack a READ
  assign bit_level = last_bit ? (is_read ? nack_bit : 1'b1)
                              : (is_read ? 1'b1 : shift_data[7]);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (run),
    .scl_oen (scl_oen),
    .scl_i   (scl_i),
    .q_last  (q_last),
    .q_first (q_first),
    .quarter (quarter)
  );

  // FSM state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-quarter SCL/SDA levels; lines hold by default
  always_comb begin
    state_next = state;
    scl_next   = scl_oen;
    sda_next   = sda_oen;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_next = ST_START;
            CMD_STOP:  state_next = ST_STOP;
            default:   state_next = ST_BIT;
          endcase
        end
      end
      ST_START: begin
        case (quarter)
          Q0: begin
            scl_next = 1'b1;
            sda_next = 1'b1;
          end
          Q2:      sda_next = 1'b0;
          Q3:      scl_next = 1'b0;
          default: ;
        endcase
        if (q_last && quarter == Q3) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      ST_STOP: begin
        case (quarter)
          Q0: begin
            scl_next = 1'b0;
            sda_next = 1'b0;
          end
          Q1:      scl_next = 1'b1;
          Q2:      sda_next = 1'b1;
          default: ;
        endcase
        if (q_last && quarter == Q3) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      ST_BIT: begin
        case (quarter)
          Q0: begin
            scl_next = 1'b0;
            sda_next = bit_level;
          end
          Q1:      scl_next = 1'b1;
          Q3:      scl_next = 1'b0;
          default: ;
        endcase
        if (q_last && quarter == Q3 && last_bit) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered open-drain enables; both lines released out of reset
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      scl_oen <= 1'b1;
      sda_oen <= 1'b1;
    end else begin
      scl_oen <= scl_next;
      sda_oen <= sda_next;
    end
  end

  // Command capture, bit counting and the shared write/read shift register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift_data <= 8'd0;
      is_read    <= 1'b0;
      nack_bit   <= 1'b0;
      ack_sample <= 1'b0;
    end else if (accept) begin
      bit_cnt    <= 4'd0;
      shift_data <= wr_data;
      is_read    <= (cmd == CMD_READ);
      nack_bit   <= cmd_nack;
    end else if (state == ST_BIT) begin
      // Sample once, on the first counted cycle of Q2 while SCL is high
      if (q_first && quarter == Q2) begin
        if (last_bit) begin
          ack_sample <= sda_i;
        end else begin
          shift_data <= {shift_data[6:0], sda_i};
        end
      end
      if (q_last && quarter == Q3) begin
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  // Completion strobes and result registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
      ack_rcvd <= 1'b0;
    end else begin
      done     <= finish;
      rd_valid <= finish & is_read & (state == ST_BIT);
      if (finish && state == ST_BIT) begin
        if (is_read) begin
          rd_data <= shift_data;
        end else begin
          ack_rcvd <= ack_sample;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed testbench for i2c_bit_engine with a scripted slave model.
module tb_i2c_bit_engine;

  localparam int CLK_DIV = 4;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_nack;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_rcvd;
  logic       done;
  logic       busy;
  logic       scl_oen;
  logic       sda_oen;
  logic       scl_i;
  logic       sda_i;

  // slave model state
  int         slave_mode = 0;   // 0 passive, 1 ack in bit 8, 2 drive slave_byte
  logic [7:0] slave_byte = 8'h00;
  int         stretch_en = 0;
  logic       slave_sda_low = 1'b0;
  logic       slave_scl_low = 1'b0;
  int         hold_left = 0;

  // monitor state
  int         cyc = 0;
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         sda_low_cnt = 0;
  int         scl_rise_cyc = 0;
  int         sda_rise_cyc = 0;
  logic [8:0] cap9 = 9'd0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  assign scl_i = scl_oen & ~slave_scl_low;
  assign sda_i = sda_oen & ~slave_sda_low;

  i2c_bit_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_nack  (cmd_nack),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ack_rcvd  (ack_rcvd),
    .done      (done),
    .busy      (busy),
    .scl_oen   (scl_oen),
    .sda_oen   (sda_oen),
    .scl_i     (scl_i),
    .sda_i     (sda_i)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Bus monitor and slave responder, evaluated away from the active edge
  always @(negedge clk_in) begin
    int rel;
    logic [2:0] idx;
    if (slave_scl_low) begin
      hold_left = hold_left - 1;
      if (hold_left == 0) slave_scl_low = 1'b0;
    end
    if (scl_oen && !prev_scl) begin
      rise_cnt     = rise_cnt + 1;
      cap9         = {cap9[7:0], sda_i};
      scl_rise_cyc = cyc;
      if (stretch_en != 0 && (fall_cnt - fall_base) == 3) begin
        slave_scl_low = 1'b1;
        hold_left     = 10;
      end
    end
    if (!scl_oen && prev_scl) fall_cnt = fall_cnt + 1;
    if (sda_oen && !prev_sda) sda_rise_cyc = cyc;
    if (!sda_oen) sda_low_cnt = sda_low_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    rel = fall_cnt - fall_base;
    slave_sda_low = 1'b0;
    if (slave_mode == 1) begin
      slave_sda_low = (rel == 8);
    end else if (slave_mode == 2 && rel >= 0 && rel < 8) begin
      idx = 3'(7 - rel);
      slave_sda_low = ~slave_byte[idx];
    end
    prev_scl = scl_oen;
    prev_sda = sda_oen;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Present a command for one cycle starting at a negedge; returns the cycle
  // stamp of the accept edge
  task automatic issue_cmd(input logic [1:0] c, input logic [7:0] d,
                           input logic nack, output int c0);
    cmd       = c;
    wr_data   = d;
    cmd_nack  = nack;
    fall_base = fall_cnt;
    cmd_valid = 1'b1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    c0 = cyc;
  endtask

  // Wait (bounded) for done; lat is -1 if it never comes
  task automatic wait_done(input int c0, output int lat, output int rdv);
    lat = -1;
    rdv = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        lat = cyc - c0;
        rdv = int'(rd_valid);
        break;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d,
                         input logic nack, output int lat, output int rdv);
    int c0;
    issue_cmd(c, d, nack, c0);
    wait_done(c0, lat, rdv);
  endtask

  initial begin
    int lat, rdv, c0, base, sda_base;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = 2'b00;
    cmd_nack = 1'b0;
    wr_data = 8'h00;

    // reset state, during and after
    @(negedge clk_in);
    check("rst_scl_oen", int'(scl_oen), 1);
    check("rst_sda_oen", int'(sda_oen), 1);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_rd_data", int'(rd_data), 8'h00);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_lines", int'({scl_oen, sda_oen}), 3);
    check("post_rst_ack", int'(ack_rcvd), 0);

    // START
    run_cmd(C_START, 8'h00, 1'b0, lat, rdv);
    check("start_latency", lat, 16);
    check("start_lines_low", int'({scl_oen, sda_oen}), 0);
    check("start_ready_with_done", int'(cmd_ready), 1);
    check("start_no_rd_valid", rdv, 0);
    @(negedge clk_in);
    check("done_one_cycle", int'(done), 0);

    // WRITE 0xA5, slave ACKs
    slave_mode = 1;
    base = rise_cnt;
    run_cmd(C_WRITE, 8'hA5, 1'b0, lat, rdv);
    check("write_latency", lat, 144);
    check("write_scl_highs", rise_cnt - base, 9);
    check("write_sda_bits", int'(cap9), 9'h14A);
    check("write_ack_rcvd", int'(ack_rcvd), 0);

    // READ 0x3C, master NACKs
    slave_mode = 2;
    slave_byte = 8'h3C;
    sda_base = sda_low_cnt;
    run_cmd(C_READ, 8'h00, 1'b1, lat, rdv);
    check("read_latency", lat, 144);
    check("read_rd_valid_at_done", rdv, 1);
    check("read_rd_data", int'(rd_data), 8'h3C);
    check("read_bus_bits", int'(cap9), 9'h079);
    check("read_master_sda_low_cycles", sda_low_cnt - sda_base, 0);
    @(negedge clk_in);
    check("rd_valid_one_cycle", int'(rd_valid), 0);

    // WRITE 0x5A with a 10-cycle stretch at bit 3 Q1, slave NACKs
    slave_mode = 0;
    stretch_en = 1;
    run_cmd(C_WRITE, 8'h5A, 1'b0, lat, rdv);
    stretch_en = 0;
    check("stretch_latency", lat, 154);
    check("stretch_sda_bits", int'(cap9), 9'h0B5);
    check("stretch_ack_rcvd", int'(ack_rcvd), 1);
    check("rd_data_held", int'(rd_data), 8'h3C);

    // Reset in the middle of a WRITE
    @(negedge clk_in);
    issue_cmd(C_WRITE, 8'h0F, 1'b0, c0);
    repeat (50) @(negedge clk_in);
    check("midwrite_busy", int'(busy), 1);
    check("midwrite_scl_driven", int'(scl_oen), 0);
    base = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_scl_released", int'(scl_oen), 1);
    check("abort_sda_released", int'(sda_oen), 1);
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_rd_data", int'(rd_data), 8'h00);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (100) @(negedge clk_in);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_idle_ready", int'(cmd_ready), 1);

    // STOP with a stray command while busy
    base = done_cnt;
    issue_cmd(C_STOP, 8'h00, 1'b0, c0);
    repeat (5) @(negedge clk_in);
    cmd = C_START;
    cmd_valid = 1'b1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    wait_done(c0, lat, rdv);
    check("stop_latency", lat, 16);
    check("stop_scl_before_sda", sda_rise_cyc - scl_rise_cyc, 4);
    repeat (40) @(negedge clk_in);
    check("stop_single_done", done_cnt - base, 1);
    check("stop_lines_released", int'({scl_oen, sda_oen}), 3);
    check("stop_ready", int'(cmd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
